// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding and frame constants.
package uart_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned FRAME_BITS = DEF_DATA_W + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

endpackage

// File: rtl/baud_ctr.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, flags the terminal count, clears on request.
module baud_ctr #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tick_c
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick_c = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign o_cnt    = r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr || o_tick_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and serialises each byte as an 8N1 frame on tx.
// Outputs are registered from next-state values so they line up with the state they describe.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_pop,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic                r_tx;
  logic                r_busy;
  logic                r_tx_done;
  logic                w_tx_nxt;
  logic                w_done_nxt;
  logic                w_clr;
  logic                w_tick;
  logic [BAUD_W-1:0]   w_baud_cnt;

  // Counter restarts at zero whenever the FSM changes state
  assign w_clr = (w_state_nxt != r_state);

  baud_ctr #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (BAUD_W)
  ) u_baud_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .o_cnt   (w_baud_cnt),
    .o_tick_c(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_tx_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    fifo_pop    = 1'b0;
    w_tx_nxt    = 1'b1;
    w_done_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        w_shift_nxt = fifo_dout;
        w_bit_nxt   = '0;
        w_state_nxt = START;
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == BIT_W'(DATA_W - 1)) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      STOP: begin
        // Registered pulse lands in the final stop-bit cycle
        w_done_nxt = (w_baud_cnt == BAUD_W'(CLKS_PER_BIT - 2));
        if (w_tick) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (rst) begin
      fifo_pop = 1'b0;
    end

    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: queue-backed byte FIFO, frame-timing reference model, line decoder.
module tb_fifo_uart_tx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DW    = 8;
  localparam int          LAST  = (DW + 2) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout  = 8'h00;
  logic       fifo_pop;
  logic       tx;
  logic       busy;
  logic       tx_done;

  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;

  bit         chk_en   = 1'b0;
  bit         rst_prev = 1'b0;
  bit         m_active = 1'b0;
  int         m_pop    = 0;
  logic [7:0] m_byte   = 8'h00;

  bit         rx_on   = 1'b0;
  int         rx_cnt  = 0;
  logic       rx_bits[10];
  logic       tx_prev = 1'b0;

  fifo_uart_tx #(
    .DATA_W      (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Byte FIFO: read data appears the cycle after a pop
  always @(posedge clk) begin
    if (fifo_pop && fq.size() > 0) fifo_dout <= fq.pop_front();
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  // Reference model: every frame is a fixed timeline counted from its pop cycle
  always @(negedge clk) begin
    int   k;
    int   fb;
    logic etx;
    logic epop;
    cyc++;
    if (chk_en) begin
      if (rst_prev) m_active = 1'b0;
      if (m_active) begin
        k = cyc - m_pop;
        if (k == 1) etx = 1'b1;
        else begin
          fb = (k - 2) / CPB;
          if (fb == 0)       etx = 1'b0;
          else if (fb <= DW) etx = m_byte[fb-1];
          else               etx = 1'b1;
        end
        chk("tx", 32'(tx), 32'(etx));
        chk("busy", 32'(busy), 32'd1);
        chk("tx_done", 32'(tx_done), 32'(k == LAST));
        chk("fifo_pop", 32'(fifo_pop), 32'd0);
        if (k == LAST) m_active = 1'b0;
      end else begin
        epop = !rst && !fifo_empty;
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tx_done", 32'(tx_done), 32'd0);
        chk("idle_fifo_pop", 32'(fifo_pop), 32'(epop));
        if (fifo_pop && epop) begin
          m_active = 1'b1;
          m_pop    = cyc;
          if (exp_q.size() > 0) m_byte = exp_q.pop_front();
          else m_byte = 8'hxx;
        end
      end
      if (fifo_pop === 1'b1) pop_cnt++;
      if (tx_done === 1'b1) done_cnt++;
    end
    if (rst) chk_en = 1'b1;
    rst_prev = rst;
  end

  // Line decoder sampling each bit at its centre
  always @(negedge clk) begin
    logic [7:0] b;
    if (rst === 1'b1) rx_on = 1'b0;
    else if (rx_on) begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        rx_bits[rx_cnt / CPB] = tx;
        if (rx_cnt / CPB == 9) begin
          for (int i = 0; i < 8; i++) b[i] = rx_bits[i+1];
          rx_q.push_back(b);
          rx_on = 1'b0;
        end
      end
    end else if (tx_prev === 1'b1 && tx === 1'b0) begin
      rx_on  = 1'b1;
      rx_cnt = 0;
    end
    tx_prev = tx;
  end

  task automatic wr(input logic [7:0] b);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("wait_pop_timeout", 32'(pop_cnt >= target), 32'd1);
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("wait_done_timeout", 32'(done_cnt >= target), 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int         bp;
    int         bd;
    int         exp_bits[10];
    logic [7:0] lst[$];
    logic [7:0] x;
    logic [7:0] y;

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    exp_bits = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

    // Reset with the FIFO empty
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);

    // Single byte 0x11
    bp = pop_cnt; bd = done_cnt; rx_q.delete();
    wr(8'h11);
    wait_dones(bd + 1, 400);
    chk("one_pops", 32'(pop_cnt - bp), 32'd1);
    chk("one_dones", 32'(done_cnt - bd), 32'd1);
    chk("one_rx_n", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("one_rx", 32'(rx_q[0]), 32'h11);
    for (int i = 0; i < 10; i++) chk("one_bit", 32'(rx_bits[i]), 32'(exp_bits[i]));

    // Burst of four
    bp = pop_cnt; bd = done_cnt; rx_q.delete();
    lst = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (lst[i]) wr(lst[i]);
    wait_dones(bd + 4, 1200);
    chk("burst_pops", 32'(pop_cnt - bp), 32'd4);
    chk("burst_rx_n", 32'(rx_q.size()), 32'd4);
    foreach (lst[i]) if (i < rx_q.size()) chk("burst_rx", 32'(rx_q[i]), 32'(lst[i]));
    chk("burst_empty", 32'(fifo_empty), 32'd1);

    // Long idle
    bp = pop_cnt;
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_pops", 32'(pop_cnt - bp), 32'd0);
    chk("idle_line", 32'(tx), 32'd1);

    // Reset during data bit 3 of 0xA5, then 0x5A
    bp = pop_cnt; bd = done_cnt; rx_q.delete();
    wr(8'hA5);
    wait_pops(bp + 1, 50);
    repeat (72) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (200) @(posedge clk);
    #1;
    chk("abort_dones", 32'(done_cnt - bd), 32'd0);
    chk("abort_rx_n", 32'(rx_q.size()), 32'd0);
    wr(8'h5A);
    wait_dones(bd + 1, 400);
    chk("after_abort_rx_n", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("after_abort_rx", 32'(rx_q[0]), 32'h5A);

    // Second byte written mid-frame
    bp = pop_cnt; bd = done_cnt; rx_q.delete();
    x = 8'($urandom); y = 8'($urandom);
    wr(x);
    wait_pops(bp + 1, 50);
    repeat (60) @(posedge clk);
    wr(y);
    chk("mid_no_pop", 32'(pop_cnt - bp), 32'd1);
    wait_dones(bd + 2, 800);
    chk("mid_pops", 32'(pop_cnt - bp), 32'd2);
    chk("mid_dones", 32'(done_cnt - bd), 32'd2);
    chk("mid_rx_n", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() > 1) begin
      chk("mid_rx0", 32'(rx_q[0]), 32'(x));
      chk("mid_rx1", 32'(rx_q[1]), 32'(y));
    end

    // Random bytes at random spacing
    bd = done_cnt; rx_q.delete(); lst.delete();
    for (int i = 0; i < 16; i++) begin
      x = 8'($urandom);
      lst.push_back(x);
      wr(x);
      repeat ($urandom_range(0, 200)) @(posedge clk);
    end
    wait_dones(bd + 16, 4000);
    chk("rand_rx_n", 32'(rx_q.size()), 32'd16);
    foreach (lst[i]) if (i < rx_q.size()) chk("rand_rx", 32'(rx_q[i]), 32'(lst[i]));

    chk("pop_vs_done", 32'(pop_cnt - done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
